gpr_wb_sched: RTL and testbench

//  Sits in front of the gpr register file and owns its single write port.
//  It keeps a 32-entry scoreboard of registers with writes in flight, and stalls

---
 rtl/gpr_wb_sched.sv | 149 ++++++++++++++
 tb/tb_gpr_wb_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_sched.sv
// gpr_wb_sched
//   Write-back scheduler in front of the gpr register file. It owns the
//   single gpr write port and keeps a 32-entry scoreboard of destination
//   registers with a write in flight.
//
//   Issue side : issue_valid/rd/wr/rs1/rs2 in, issue_stall out. The stall is
//                combinational and covers RAW (rs1/rs2 busy) and WAW (rd busy).
//                A non-stalled writing issue to rd!=0 reserves busy[rd].
//   Producers  : req_valid/reg/data/byte in (NREQ lanes, packed slices),
//                req_ready out (one-hot grant, round-robin, combinational).
//   gpr port   : w_en/w_byte/wreg/wdata out, registered, one cycle after the
//                transfer. busy[wreg] clears on the edge where w_en=1.
//   Debug      : busy is the scoreboard; busy[0] is always 0.
module gpr_wb_sched #(
    parameter int NREQ = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    input  logic                 issue_wr,
    input  logic [4:0]           issue_rs1,
    input  logic [4:0]           issue_rs2,
    output logic                 issue_stall,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_reg,
    input  logic [32*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]      req_byte,
    output logic [NREQ-1:0]      req_ready,
    output logic                 w_en,
    output logic                 w_byte,
    output logic [4:0]           wreg,
    output logic [31:0]          wdata,
    output logic [31:0]          busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // State
    logic [31:0]      busy_q,   busy_d;
    logic [PTR_W-1:0] ptr_q,    ptr_d;
    logic             w_en_q,   w_en_d;
    logic             w_byte_q, w_byte_d;
    logic [4:0]       wreg_q,   wreg_d;
    logic [31:0]      wdata_q,  wdata_d;

    // Per-lane views of the packed request buses
    logic [4:0]  lane_reg  [NREQ];
    logic [31:0] lane_data [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            assign lane_reg[gi]  = req_reg[5*gi +: 5];
            assign lane_data[gi] = req_data[32*gi +: 32];
        end
    endgenerate

    // Round-robin grant: search from ptr+1 and wrap, first valid lane wins.
    logic [NREQ-1:0]  grant_oh;
    logic [PTR_W-1:0] grant_idx;
    logic             xfer;
    logic [PTR_W-1:0] scan_idx;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        xfer      = 1'b0;
        scan_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = PTR_W'((int'(ptr_q) + k) % NREQ);
            if (!xfer && req_valid[scan_idx]) begin
                xfer               = 1'b1;
                grant_oh[scan_idx] = 1'b1;
                grant_idx          = scan_idx;
            end
        end
        // No grants while held in reset.
        if (rst) begin
            grant_oh = '0;
            xfer     = 1'b0;
        end
    end

    assign req_ready = grant_oh;

    // Hazard detection against the scoreboard. No bypass of a clear that is
    // committing this cycle: the dependent leaves stall the cycle after.
    logic reserve;

    assign issue_stall = rst | (issue_valid & (busy_q[issue_rs1] | busy_q[issue_rs2] |
                                               (issue_wr & busy_q[issue_rd])));
    assign reserve     = issue_valid & ~issue_stall & issue_wr & (issue_rd != 5'd0);

    // Next-state
    always_comb begin
        busy_d   = busy_q;
        ptr_d    = ptr_q;
        w_en_d   = 1'b0;
        w_byte_d = w_byte_q;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;

        // Clear first, then set: a new reservation of the same register on
        // the commit edge belongs to the new producer and must survive.
        if (w_en_q) begin
            busy_d[wreg_q] = 1'b0;
        end
        if (reserve) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        if (xfer) begin
            ptr_d    = grant_idx;
            // r0 writes are accepted from the producer but never reach gpr.
            w_en_d   = (lane_reg[grant_idx] != 5'd0);
            w_byte_d = req_byte[grant_idx];
            wreg_d   = lane_reg[grant_idx];
            wdata_d  = lane_data[grant_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            ptr_q    <= PTR_W'(NREQ - 1);
            w_en_q   <= 1'b0;
            w_byte_q <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
        end else begin
            busy_q   <= busy_d;
            ptr_q    <= ptr_d;
            w_en_q   <= w_en_d;
            w_byte_q <= w_byte_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
        end
    end

    // A staged write present while reset is asserted must not commit at the
    // reset edge, so the enable is masked by rst.
    assign w_en   = w_en_q & ~rst;
    assign w_byte = w_byte_q;
    assign wreg   = wreg_q;
    assign wdata  = wdata_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_gpr_wb_sched.sv
// tb_gpr_wb_sched
//   Directed bench for gpr_wb_sched. Inputs change 1ns after posedge, outputs
//   are checked at negedge. A small gpr model records what commits through
//   the write port.
module tb_gpr_wb_sched;

    localparam int NREQ = 3;

    logic                clk;
    logic                rst;
    logic                issue_valid;
    logic [4:0]          issue_rd;
    logic                issue_wr;
    logic [4:0]          issue_rs1;
    logic [4:0]          issue_rs2;
    logic                issue_stall;
    logic [NREQ-1:0]     req_valid;
    logic [5*NREQ-1:0]   req_reg;
    logic [32*NREQ-1:0]  req_data;
    logic [NREQ-1:0]     req_byte;
    logic [NREQ-1:0]     req_ready;
    logic                w_en;
    logic                w_byte;
    logic [4:0]          wreg;
    logic [31:0]         wdata;
    logic [31:0]         busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] gpr_m [32] = '{default: 32'd0};

    gpr_wb_sched #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_wr    (issue_wr),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_stall (issue_stall),
        .req_valid   (req_valid),
        .req_reg     (req_reg),
        .req_data    (req_data),
        .req_byte    (req_byte),
        .req_ready   (req_ready),
        .w_en        (w_en),
        .w_byte      (w_byte),
        .wreg        (wreg),
        .wdata       (wdata),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // gpr model: commits whatever the write port presents at a posedge.
    always @(posedge clk) begin
        if (w_en) begin
            if (w_byte) gpr_m[wreg][7:0] <= wdata[7:0];
            else        gpr_m[wreg]      <= wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("chk  %s got=%h ok", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d, input logic b);
        req_reg[5*i +: 5]   = r;
        req_data[32*i +: 32] = d;
        req_byte[i]         = b;
    endtask

    task automatic set_issue(input logic v, input logic [4:0] rd, input logic wr,
                             input logic [4:0] rs1, input logic [4:0] rs2);
        issue_valid = v;
        issue_rd    = rd;
        issue_wr    = wr;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
    endtask

    initial begin
        // T1: reset with all inputs active
        rst       = 1'b1;
        req_reg   = '0;
        req_data  = '0;
        req_byte  = '0;
        set_issue(1'b1, 5'd1, 1'b1, 5'd2, 5'd3);
        req_valid = 3'b111;
        for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), 32'hCAFE0000 + 32'(i), 1'b0);
        tick();
        tick();
        mid();
        chk("t1_busy",  busy, 32'd0);
        chk("t1_wen",   {31'd0, w_en}, 32'd0);
        chk("t1_ready", {29'd0, req_ready}, 32'd0);
        chk("t1_stall", {31'd0, issue_stall}, 32'd1);
        tick();
        rst = 1'b0;
        set_issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        req_valid = 3'b001;
        set_req(0, 5'd4, 32'h00000011, 1'b0);
        mid();
        chk("t1_grant0", {29'd0, req_ready}, 32'h1);
        tick();
        req_valid = 3'b000;
        mid();
        chk("t1_wen1",  {31'd0, w_en}, 32'd1);
        chk("t1_wreg",  {27'd0, wreg}, 32'd4);
        chk("t1_wdata", wdata, 32'h00000011);
        tick();

        // T2: RAW stall until LSU write-back of r5 commits
        set_issue(1'b1, 5'd5, 1'b1, 5'd0, 5'd0);
        mid();
        chk("t2_nostall", {31'd0, issue_stall}, 32'd0);
        tick();
        set_issue(1'b1, 5'd0, 1'b0, 5'd5, 5'd0);
        mid();
        chk("t2_stall_a", {31'd0, issue_stall}, 32'd1);
        chk("t2_busy5",   {31'd0, busy[5]}, 32'd1);
        tick();
        mid();
        chk("t2_stall_b", {31'd0, issue_stall}, 32'd1);
        tick();
        req_valid = 3'b010;
        set_req(1, 5'd5, 32'hDEADBEEF, 1'b0);
        mid();
        chk("t2_ready1",  {29'd0, req_ready}, 32'h2);
        chk("t2_stall_c", {31'd0, issue_stall}, 32'd1);
        tick();
        req_valid = 3'b000;
        mid();
        chk("t2_wen",     {31'd0, w_en}, 32'd1);
        chk("t2_wreg",    {27'd0, wreg}, 32'd5);
        chk("t2_wdata",   wdata, 32'hDEADBEEF);
        chk("t2_stall_d", {31'd0, issue_stall}, 32'd1);
        tick();
        mid();
        chk("t2_release", {31'd0, issue_stall}, 32'd0);
        chk("t2_busy5_0", {31'd0, busy[5]}, 32'd0);
        chk("t2_gpr5",    gpr_m[5], 32'hDEADBEEF);
        chk("t2_wen0",    {31'd0, w_en}, 32'd0);
        tick();
        set_issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);

        // Reset pulse puts the pointer back at NREQ-1
        rst = 1'b1;
        mid();
        tick();
        rst = 1'b0;

        // T3: round robin with all three requesters held valid
        for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), 32'h000000A0 + 32'(i), 1'b0);
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            logic [31:0] exp_oh;
            exp_oh = 32'd1 << (c % 3);
            mid();
            chk($sformatf("t3_grant_c%0d", c), {29'd0, req_ready}, exp_oh);
            if (c > 0) begin
                chk($sformatf("t3_wen_c%0d", c),  {31'd0, w_en}, 32'd1);
                chk($sformatf("t3_wreg_c%0d", c), {27'd0, wreg}, 32'((c - 1) % 3 + 1));
            end
            tick();
        end
        req_valid = 3'b000;
        mid();
        chk("t3_wen_last",   {31'd0, w_en}, 32'd1);
        chk("t3_wreg_last",  {27'd0, wreg}, 32'd3);
        chk("t3_wdata_last", wdata, 32'h000000A2);
        tick();

        // T5: r0 request is swallowed, byte write to r3 clears busy[3]
        set_issue(1'b1, 5'd3, 1'b1, 5'd0, 5'd0);
        mid();
        chk("t5_nostall", {31'd0, issue_stall}, 32'd0);
        tick();
        set_issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        req_valid = 3'b001;
        set_req(0, 5'd0, 32'h12345678, 1'b0);
        mid();
        chk("t5_ready_r0", {29'd0, req_ready}, 32'h1);
        chk("t5_busy3",    {31'd0, busy[3]}, 32'd1);
        tick();
        set_req(0, 5'd3, 32'h000000AB, 1'b1);
        mid();
        chk("t5_ready_b",  {29'd0, req_ready}, 32'h1);
        chk("t5_wen_r0",   {31'd0, w_en}, 32'd0);
        tick();
        req_valid = 3'b000;
        mid();
        chk("t5_wen",    {31'd0, w_en}, 32'd1);
        chk("t5_wbyte",  {31'd0, w_byte}, 32'd1);
        chk("t5_wreg",   {27'd0, wreg}, 32'd3);
        chk("t5_wdata",  {24'd0, wdata[7:0]}, 32'h000000AB);
        tick();
        set_req(0, 5'd0, 32'd0, 1'b0);
        mid();
        chk("t5_busy3_0", {31'd0, busy[3]}, 32'd0);
        chk("t5_gpr3",    gpr_m[3], 32'h000000AB);
        tick();

        // T4: write to r7 commits on the same edge a new issue reserves r7
        req_valid = 3'b010;
        set_req(1, 5'd7, 32'h00000077, 1'b0);
        mid();
        chk("t4_ready1", {29'd0, req_ready}, 32'h2);
        tick();
        req_valid = 3'b000;
        set_issue(1'b1, 5'd7, 1'b1, 5'd0, 5'd0);
        mid();
        chk("t4_wen",     {31'd0, w_en}, 32'd1);
        chk("t4_wreg",    {27'd0, wreg}, 32'd7);
        chk("t4_nostall", {31'd0, issue_stall}, 32'd0);
        tick();
        mid();
        chk("t4_busy7",    {31'd0, busy[7]}, 32'd1);
        chk("t4_waw_stall", {31'd0, issue_stall}, 32'd1);
        tick();
        set_issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);

        // T6: reset while r9 is reserved and its write is staged
        set_issue(1'b1, 5'd9, 1'b1, 5'd0, 5'd0);
        mid();
        chk("t6_nostall", {31'd0, issue_stall}, 32'd0);
        tick();
        set_issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        req_valid = 3'b100;
        set_req(2, 5'd9, 32'h00000099, 1'b0);
        mid();
        chk("t6_ready2", {29'd0, req_ready}, 32'h4);
        chk("t6_busy9",  {31'd0, busy[9]}, 32'd1);
        tick();
        req_valid = 3'b000;
        rst = 1'b1;
        mid();
        chk("t6_wen_rst",   {31'd0, w_en}, 32'd0);
        chk("t6_ready_rst", {29'd0, req_ready}, 32'd0);
        tick();
        rst = 1'b0;
        mid();
        chk("t6_busy",  busy, 32'd0);
        chk("t6_wen",   {31'd0, w_en}, 32'd0);
        chk("t6_gpr9",  gpr_m[9], 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
